// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: command front end for the 8-bit ALU, holding an accumulator
// and iterating single-bit ALU shifts to carry out multi-bit shifts.
module alu_cmd_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [3:0] cmd_op_i,
  input  logic [7:0] cmd_data_i,
  output logic [7:0] alu_a_o,
  output logic [4:0] alu_b_o,
  output logic [2:0] alu_op_o,
  input  logic [7:0] alu_result_i,
  input  logic [3:0] alu_flags_i,
  output logic       res_valid_o,
  input  logic       res_ready_i,
  output logic [7:0] res_data_o,
  output logic [3:0] res_flags_o,
  output logic       res_err_o
);
  typedef enum logic [1:0] {IDLE, EXEC, OUT} state_e;
  state_e     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [3:0] flags_q, flags_d;
  logic [2:0] cnt_q, cnt_d;
  logic [4:0] b_q, b_d;
  logic [2:0] op_q, op_d;
  logic       err_q, err_d;
  logic       accept;
  assign cmd_ready_o = (state_q == IDLE) && !rst;
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign alu_a_o     = acc_q;
  assign alu_b_o     = b_q;
  assign alu_op_o    = op_q;
  assign res_valid_o = (state_q == OUT) && !rst;
  assign res_data_o  = acc_q;
  assign res_flags_o = flags_q;
  assign res_err_o   = err_q;
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    flags_d = flags_q;
    cnt_d   = cnt_q;
    b_d     = b_q;
    op_d    = op_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = OUT;
        if (!cmd_op_i[3]) begin
          op_d    = cmd_op_i[2:0];
          b_d     = cmd_data_i[4:0];
          cnt_d   = 3'd0;
          state_d = EXEC;
        end else if (cmd_op_i[2]) begin
          err_d = 1'b1;
        end else if (cmd_op_i[1:0] == 2'b00) begin
          acc_d   = cmd_data_i;
          flags_d = {2'b00, cmd_data_i[7], cmd_data_i == 8'd0};
        end else if (cmd_op_i[1:0] != 2'b11) begin
          // SHLN (01) maps to ALU shl 100, SHRN (10) to shr 101
          if (cmd_data_i[2:0] == 3'd0) begin
            flags_d = {2'b00, acc_q[7], acc_q == 8'd0};
          end else begin
            op_d    = {2'b10, cmd_op_i[1]};
            b_d     = 5'd0;
            cnt_d   = cmd_data_i[2:0] - 3'd1;
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        acc_d   = alu_result_i;
        flags_d = alu_flags_i;
        cnt_d   = (cnt_q == 3'd0) ? cnt_q : cnt_q - 3'd1;
        state_d = (cnt_q == 3'd0) ? OUT : EXEC;
      end
      OUT: if (res_ready_i) begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      flags_q <= '0;
      cnt_q   <= '0;
      b_q     <= '0;
      op_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
      b_q     <= b_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-driven front end that sits directly upstream of the 8-bit combinational ALU. It holds an 8-bit accumulator and accepts commands over a valid/ready handshake. It drives the ALU's A, B[4:0] and opcode[2:0] inputs, captures the ALU result and the {carry, overflow, negative, zero} flags back into the accumulator, and returns each command's result over a second valid/ready handshake. Multi-bit shifts are executed by iterating the ALU's single-bit shift ops.

## Interface
- No parameters; widths are fixed by the ALU: 8-bit data, 5-bit B, 3-bit opcode, 4-bit flags.
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block accepts a command this cycle
- cmd_op  in  4  command code (see Operation)
- cmd_data  in  8  immediate operand / shift count
- alu_a  out  8  ALU input A; wired from the accumulator register
- alu_b  out  5  ALU input B, registered
- alu_op  out  3  ALU opcode, registered
- alu_result  in  8  ALU result (combinational)
- alu_flags  in  4  ALU flags {C,V,N,Z}
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- res_data  out  8  accumulator value after the command
- res_flags  out  4  flags register {C,V,N,Z}
- res_err  out  1  command was illegal

## Operation
- Registers: acc[7:0], flags[3:0], cnt[2:0], alu_b, alu_op, and the state register.
- States:
  - IDLE: cmd_ready=1.
  - EXEC: ALU inputs are stable; the ALU output is captured at the end of this cycle.
  - OUT: res_valid=1.
- cmd_op decode on accept, when cmd_valid & cmd_ready are both 1:
  - 0ooo (ALU op): alu_op<=ooo, alu_b<=cmd_data[4:0], cnt<=0, go to EXEC.
  - 1000 LOAD: acc<=cmd_data, flags<={0,0,cmd_data[7],cmd_data==0}, go to OUT.
  - 1001 SHLN: n=cmd_data[2:0]. If n=0, go to OUT with flags<={0,0,acc[7],acc==0}. Otherwise alu_op<=100, alu_b<=0, cnt<=n-1, go to EXEC.
  - 1010 SHRN: as SHLN, with alu_op<=101.
  - 1011 READ: go to OUT; acc and flags are unchanged.
  - 11xx: illegal. Go to OUT with res_err=1; acc and flags are unchanged.
- EXEC, every cycle:
  - acc<=alu_result, flags<=alu_flags.
  - If cnt==0, go to OUT. Otherwise cnt<=cnt-1 and stay in EXEC.
  - On the next iteration alu_a already shows the updated acc.
- OUT:
  - res_data=acc, res_flags=flags, res_err as latched at accept.
  - On res_valid & res_ready, go to IDLE and clear res_err.
  - res_data, res_flags and res_err hold stable while res_valid=1 and res_ready=0.
- ALU ops 110/111 are issued unmodified; the ALU returns 0, and flags are captured as returned.
- The accumulator is never written outside LOAD and EXEC.

## Timing
- Reset values while rst=1 and on the first cycle after it:
  - state=IDLE.
  - acc, flags, cnt, alu_b, alu_op, res_data, res_flags all 0.
  - res_valid=0, res_err=0.
- cmd_ready is forced to 0 while rst=1; it is 1 on the first cycle after rst deasserts.
- Latency, with the command accepted at edge T:
  - LOAD, READ, illegal: res_valid=1 from cycle T+1.
  - ALU op: one EXEC cycle; res_valid from T+2.
  - SHLN/SHRN with n>0: n EXEC cycles; res_valid from T+1+n.
  - SHLN/SHRN with n=0: res_valid from T+1.
- Throughput:
  - cmd_ready=0 in EXEC and OUT, so there is no overlap between commands.
  - The earliest next accept is the cycle after the result handshake.
- cmd_valid in EXEC or OUT is ignored; the command is not consumed.
- res_ready held at 1 in OUT: handshake on the first OUT cycle, IDLE on the next.
- Reset mid-EXEC or mid-OUT: the command is abandoned and no result is emitted. acc returns to 0.

## Test plan
- Reset then LOAD: rst high for 2 cycles, then LOAD 0x7F with res_ready=1.
  - cmd_ready rises on the first cycle after reset.
  - res_valid at T+1 with res_data=0x7F, res_flags=0000.
- ALU add after LOAD: LOAD 0x7F, then op 000 with data 0x01.
  - alu_a=0x7F, alu_b=0x01, alu_op=000 during EXEC.
  - res_valid at T+2 with res_data=0x80, res_flags=0110 (V,N).
- Shift left by 3: LOAD 0x81, then SHLN 3.
  - alu_a sequence 0x81, 0x02, 0x04.
  - res_valid at T+4 with res_data=0x08, res_flags=0000.
- SHRN by 0: SHRN 0 with acc=0x00.
  - No EXEC cycle; res_valid at T+1 with res_data=0x00, res_flags=0001.
- Backpressure and illegal command: READ with res_ready=0 for 5 cycles.
  - res_valid, res_data and res_flags stay stable.
  - cmd_valid with a LOAD is not accepted meanwhile.
  - Then illegal 1100 gives res_err=1 with acc unchanged.
- Reset mid-shift: SHLN 7 is interrupted by rst at T+3.
  - No res_valid; acc=0.
  - cmd_ready=1 on the cycle after rst deasserts.
